// File: rtl/flag_status_register.sv
// Architectural NZCV status register with masked commit, a single saved copy
// for exception entry/return, and a registered condition-code evaluator.
module flag_status_register #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_we,
    input  logic [3:0] flag_mask,
    input  logic       n_in,
    input  logic       z_in,
    input  logic       c_in,
    input  logic       v_in,
    input  logic       exc_entry,
    input  logic       exc_return,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    output logic [3:0] flags_q,
    output logic [3:0] saved_flags,
    output logic       cond_valid_q,
    output logic       cond_pass_q
);

    typedef enum logic [3:0] {
        CC_EQ = 4'h0,
        CC_NE = 4'h1,
        CC_CS = 4'h2,
        CC_CC = 4'h3,
        CC_MI = 4'h4,
        CC_PL = 4'h5,
        CC_VS = 4'h6,
        CC_VC = 4'h7,
        CC_HI = 4'h8,
        CC_LS = 4'h9,
        CC_GE = 4'hA,
        CC_LT = 4'hB,
        CC_GT = 4'hC,
        CC_LE = 4'hD,
        CC_AL = 4'hE,
        CC_NV = 4'hF
    } cond_code_e;

    logic [3:0] new_flags;
    logic [3:0] eff_flags;
    logic [3:0] flags_d;
    logic [3:0] saved_flags_d;
    logic       cond_valid_d;
    logic       cond_pass_d;
    logic       eval_result;

    // Flag inputs only reach state through the flag_we-qualified mask path.
    always_comb begin
        new_flags = flags_q;
        if (flag_we) begin
            new_flags = ({n_in, z_in, c_in, v_in} & flag_mask) | (flags_q & ~flag_mask);
        end
    end

    always_comb begin
        eff_flags = flags_q;
        if (exc_return) begin
            eff_flags = saved_flags;
        end else if (flag_we) begin
            eff_flags = new_flags;
        end
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = eff_flags;
        eval_result  = 1'b0;
        unique case (cond_code_e'(cond))
            CC_EQ: eval_result = z;
            CC_NE: eval_result = ~z;
            CC_CS: eval_result = c;
            CC_CC: eval_result = ~c;
            CC_MI: eval_result = n;
            CC_PL: eval_result = ~n;
            CC_VS: eval_result = v;
            CC_VC: eval_result = ~v;
            CC_HI: eval_result = c & ~z;
            CC_LS: eval_result = ~c | z;
            CC_GE: eval_result = (n == v);
            CC_LT: eval_result = (n != v);
            CC_GT: eval_result = ~z & (n == v);
            CC_LE: eval_result = z | (n != v);
            CC_AL: eval_result = 1'b1;
            CC_NV: eval_result = 1'b0;
            default: eval_result = 1'b0;
        endcase
    end

    always_comb begin
        flags_d       = eff_flags;
        saved_flags_d = saved_flags;
        cond_valid_d  = cond_valid;
        cond_pass_d   = cond_valid & eval_result;
        // exc_return takes precedence over a simultaneous exc_entry.
        if (exc_entry && !exc_return) begin
            saved_flags_d = eff_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= RESET_FLAGS;
            saved_flags  <= RESET_FLAGS;
            cond_valid_q <= 1'b0;
            cond_pass_q  <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            saved_flags  <= saved_flags_d;
            cond_valid_q <= cond_valid_d;
            cond_pass_q  <= cond_pass_d;
        end
    end

endmodule

// File: tb/tb_flag_status_register.sv
// Directed bench for flag_status_register: masked writes, bypass, exception
// save/restore, reset priority and a full condition-code sweep.
module tb_flag_status_register;

    logic       clk;
    logic       reset;
    logic       flag_we;
    logic [3:0] flag_mask;
    logic       n_in, z_in, c_in, v_in;
    logic       exc_entry;
    logic       exc_return;
    logic       cond_valid;
    logic [3:0] cond;
    logic [3:0] flags_q;
    logic [3:0] saved_flags;
    logic       cond_valid_q;
    logic       cond_pass_q;

    int unsigned n_checks;
    int unsigned n_fails;

    flag_status_register #(.RESET_FLAGS(4'b0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .flag_we      (flag_we),
        .flag_mask    (flag_mask),
        .n_in         (n_in),
        .z_in         (z_in),
        .c_in         (c_in),
        .v_in         (v_in),
        .exc_entry    (exc_entry),
        .exc_return   (exc_return),
        .cond_valid   (cond_valid),
        .cond         (cond),
        .flags_q      (flags_q),
        .saved_flags  (saved_flags),
        .cond_valid_q (cond_valid_q),
        .cond_pass_q  (cond_pass_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset      = 1'b0;
        flag_we    = 1'b0;
        flag_mask  = 4'b0000;
        {n_in, z_in, c_in, v_in} = 4'b0000;
        exc_entry  = 1'b0;
        exc_return = 1'b0;
        cond_valid = 1'b0;
        cond       = 4'h0;
    endtask

    // Apply the currently driven inputs for one clock, then settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic [3:0] mask, input logic [3:0] nzcv);
        clear_inputs();
        flag_we   = 1'b1;
        flag_mask = mask;
        {n_in, z_in, c_in, v_in} = nzcv;
    endtask

    task automatic ask(input logic [3:0] cc);
        cond_valid = 1'b1;
        cond       = cc;
    endtask

    function automatic logic ref_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clear_inputs();
        #2;

        // Reset, then idle
        reset = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("rst_flags", flags_q, 4'b0000);
        check("rst_saved", saved_flags, 4'b0000);
        check("rst_cv", {3'b0, cond_valid_q}, 4'd0);
        check("rst_cp", {3'b0, cond_pass_q}, 4'd0);

        ask(4'hE); tick();
        check("al_cv", {3'b0, cond_valid_q}, 4'd1);
        check("al_cp", {3'b0, cond_pass_q}, 4'd1);
        clear_inputs(); ask(4'hF); tick();
        check("nv_cv", {3'b0, cond_valid_q}, 4'd1);
        check("nv_cp", {3'b0, cond_pass_q}, 4'd0);
        clear_inputs(); tick();
        check("idle_cv", {3'b0, cond_valid_q}, 4'd0);
        check("idle_cp", {3'b0, cond_pass_q}, 4'd0);

        // Partial mask write
        write_flags(4'b0100, 4'b1111); tick();
        check("mask_flags", flags_q, 4'b0100);
        clear_inputs(); ask(4'h0); tick();
        check("eq_pass", {3'b0, cond_pass_q}, 4'd1);
        clear_inputs(); ask(4'h4); tick();
        check("mi_pass", {3'b0, cond_pass_q}, 4'd0);
        write_flags(4'b0000, 4'b1011); tick();
        check("zero_mask", flags_q, 4'b0100);

        // Same-cycle write bypass into condition evaluation
        write_flags(4'b1111, 4'b0000); tick();
        check("clr_flags", flags_q, 4'b0000);
        write_flags(4'b1111, 4'b1001); ask(4'hA); tick();
        check("byp_ge_pass", {3'b0, cond_pass_q}, 4'd1);
        check("byp_flags", flags_q, 4'b1001);
        write_flags(4'b1111, 4'b0000); tick();
        write_flags(4'b1111, 4'b1000); ask(4'hA); tick();
        check("byp_ge_fail", {3'b0, cond_pass_q}, 4'd0);
        clear_inputs(); ask(4'hB); tick();
        check("lt_pass", {3'b0, cond_pass_q}, 4'd1);

        // Exception entry with same-cycle write, then restore
        write_flags(4'b1111, 4'b0110); tick();
        check("pre_exc", flags_q, 4'b0110);
        write_flags(4'b0001, 4'b1111); exc_entry = 1'b1; tick();
        check("entry_saved", saved_flags, 4'b0111);
        check("entry_flags", flags_q, 4'b0111);
        write_flags(4'b1111, 4'b1000); tick();
        check("post_wr", flags_q, 4'b1000);
        check("post_wr_saved", saved_flags, 4'b0111);
        write_flags(4'b1111, 4'b1111); exc_return = 1'b1; ask(4'h9); tick();
        check("ret_flags", flags_q, 4'b0111);
        check("ret_saved", saved_flags, 4'b0111);
        check("ret_ls", {3'b0, cond_pass_q}, 4'd1);
        write_flags(4'b1111, 4'b1111); tick();
        write_flags(4'b1111, 4'b1111); exc_return = 1'b1; ask(4'h4); tick();
        check("ret_mi", {3'b0, cond_pass_q}, 4'd0);
        check("ret2_flags", flags_q, 4'b0111);

        // Entry and return together: return wins
        write_flags(4'b1111, 4'b0011); exc_entry = 1'b1; tick();
        check("setup_saved", saved_flags, 4'b0011);
        write_flags(4'b1111, 4'b1100); tick();
        check("setup_flags", flags_q, 4'b1100);
        clear_inputs(); exc_entry = 1'b1; exc_return = 1'b1; tick();
        check("conf_flags", flags_q, 4'b0011);
        check("conf_saved", saved_flags, 4'b0011);

        // Reset overrides a same-cycle write and condition request
        write_flags(4'b1111, 4'b1111); tick();
        write_flags(4'b1111, 4'b1111); ask(4'hE); exc_entry = 1'b1; reset = 1'b1; tick();
        check("mrst_flags", flags_q, 4'b0000);
        check("mrst_saved", saved_flags, 4'b0000);
        check("mrst_cv", {3'b0, cond_valid_q}, 4'd0);
        check("mrst_cp", {3'b0, cond_pass_q}, 4'd0);

        // Full condition table sweep through the bypass path
        for (int unsigned f = 0; f < 16; f++) begin
            for (int unsigned cc = 0; cc < 16; cc++) begin
                write_flags(4'b1111, 4'(f)); ask(4'(cc)); tick();
                check($sformatf("sweep_c%0h_f%0h", cc, f), {3'b0, cond_pass_q},
                      {3'b0, ref_eval(4'(cc), 4'(f))});
            end
        end

        clear_inputs();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
